uart_instr_loader: RTL and testbench

UART-to-instruction-memory writer: receives 8N1 serial bytes from the host, packs each group of four bytes into one instruction word, and writes the words sequentially into the instruction memory that the FSM controller later reads through its PC-addressed fetch port. It is the write-side counterpart of the controller's `rd_addr`/`rd_data` fetch path and feeds the memory's write port directly. It has a single clock domain; only `rx` is asynchronous.

---
 rtl/uart_instr_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_instr_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_instr_loader.sv
// uart_instr_loader: 8N1 UART receiver that packs incoming bytes (first byte
// in the MSB) into instruction words. Each word is written sequentially into
// the instruction memory's write port.
module uart_instr_loader #(
   parameter int F_CLK        = 50_000_000,
   parameter int BAUD         = 921_600,
   parameter int CLK_PER_BIT  = F_CLK / BAUD,
   parameter int INSTR_WIDTH  = 32,
   parameter int INSTR_DEPTH  = 256,
   parameter int PC_WIDTH     = $clog2(INSTR_DEPTH),
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx,
   input  logic                   load_en,
   input  logic                   clear,
   output logic                   wr_en,
   output logic [PC_WIDTH-1:0]    wr_addr,
   output logic [INSTR_WIDTH-1:0] wr_data,
   output logic [PC_WIDTH:0]      words_loaded,
   output logic                   full,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int BYTES   = INSTR_WIDTH / 8;
   localparam int TIMER_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam int IDX_W   = $clog2(BYTES + 1);
   localparam int GAP_MAX = TIMEOUT_BITS * CLK_PER_BIT;
   localparam int GAP_W   = $clog2(GAP_MAX + 1);
   localparam int CNT_W   = PC_WIDTH + 1;

   localparam logic [TIMER_W-1:0]  HALF_LAST = TIMER_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [TIMER_W-1:0]  FULL_LAST = TIMER_W'(CLK_PER_BIT - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(BYTES - 1);
   localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(GAP_MAX - 1);
   localparam logic [PC_WIDTH-1:0] PTR_LAST  = PC_WIDTH'(INSTR_DEPTH - 1);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(INSTR_DEPTH - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t                state, state_next;
   logic                     rx_meta, rx_sync, rx_prev;
   logic                     fall, half_tick, full_tick;
   logic [TIMER_W-1:0]       timer;
   logic [2:0]               bit_idx;
   logic [7:0]               rx_byte;
   logic                     timer_clr, shift_en, byte_done, stop_ok;
   logic [INSTR_WIDTH-1:0]   word;
   logic [INSTR_WIDTH+7:0]   word_ext;
   logic [INSTR_WIDTH-1:0]   word_next;
   logic [IDX_W-1:0]         byte_idx;
   logic [GAP_W-1:0]         gap_cnt;
   logic [PC_WIDTH-1:0]      ptr;

   assign fall      = rx_prev & ~rx_sync;
   assign half_tick = (timer == HALF_LAST);
   assign full_tick = (timer == FULL_LAST);
   assign word_ext  = {word, rx_byte};
   assign word_next = word_ext[INSTR_WIDTH-1:0];
   assign busy      = (state != RX_IDLE) || (byte_idx != '0);

   // Two-flop synchronizer on the idle-high line plus a delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // RX FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= RX_IDLE;
      else        state <= state_next;
   end

   // RX FSM next-state logic; STOP leaves right after its mid-bit sample so a following start edge is never missed
   always_comb begin
      state_next = state;
      case (state)
         RX_IDLE:  if (fall) state_next = RX_START;
         RX_START: if (half_tick) state_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && bit_idx == 3'd7) state_next = RX_STOP;
         RX_STOP:  if (full_tick) state_next = RX_IDLE;
         default:  state_next = RX_IDLE;
      endcase
   end

   // RX FSM outputs: bit-timer restarts at every sample point, data shifts on full-bit ticks
   always_comb begin
      timer_clr = 1'b0;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      stop_ok   = 1'b0;
      case (state)
         RX_IDLE:  timer_clr = 1'b1;
         RX_START: timer_clr = half_tick;
         RX_DATA: begin
            timer_clr = full_tick;
            shift_en  = full_tick;
         end
         RX_STOP: begin
            timer_clr = full_tick;
            byte_done = full_tick;
            stop_ok   = full_tick & rx_sync;
         end
         default:  timer_clr = 1'b1;
      endcase
   end

   // Bit timer, data-bit counter and LSB-first shift register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer   <= '0;
         bit_idx <= '0;
         rx_byte <= '0;
      end else begin
         timer <= timer_clr ? '0 : timer + 1'b1;
         if (state != RX_DATA) bit_idx <= '0;
         else if (shift_en)    bit_idx <= bit_idx + 1'b1;
         if (shift_en) rx_byte <= {rx_sync, rx_byte[7:1]};
      end
   end

   // Word assembly, write strobe, pointer/count bookkeeping and partial-word timeout; clear wins over a completing byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         words_loaded <= '0;
         full         <= 1'b0;
         frame_err    <= 1'b0;
         word         <= '0;
         byte_idx     <= '0;
         gap_cnt      <= '0;
         ptr          <= '0;
      end else begin
         wr_en <= 1'b0;
         if (clear) begin
            ptr          <= '0;
            words_loaded <= '0;
            full         <= 1'b0;
            frame_err    <= 1'b0;
            byte_idx     <= '0;
            gap_cnt      <= '0;
         end else begin
            if (wr_en) begin
               words_loaded <= words_loaded + 1'b1;
               full         <= (words_loaded == CNT_LAST);
               if (ptr != PTR_LAST) ptr <= ptr + 1'b1;
            end
            if (byte_done) begin
               gap_cnt <= '0;
               if (!stop_ok) begin
                  frame_err <= 1'b1;
                  byte_idx  <= '0;
               end else if (load_en && !full) begin
                  word <= word_next;
                  if (byte_idx == IDX_LAST) begin
                     wr_en    <= 1'b1;
                     wr_data  <= word_next;
                     wr_addr  <= ptr;
                     byte_idx <= '0;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end else if (byte_idx != '0) begin
               if (gap_cnt == GAP_LAST) begin
                  byte_idx <= '0;
                  gap_cnt  <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end else begin
               gap_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_instr_loader.sv
// tb_uart_instr_loader: drives serial frames into uart_instr_loader and checks
// writes and status flags against a byte-level reference model.
module tb_uart_instr_loader;

   localparam int CPB   = 54;
   localparam int DEPTH = 4;
   localparam int PCW   = 2;
   // pin-to-sync (2) + start half-bit + 8 data bits + stop sample, then one registered cycle
   localparam int WRITE_LATENCY = 2 + CPB / 2 + 9 * CPB + 1;
   // timeout is 20 bit times between stop samples; a frame itself spans 10 of them
   localparam int GAP_IDLE_BITS = 10;

   typedef struct {
      int          addr;
      logic [31:0] data;
      longint      cyc;
   } wr_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rx;
   logic             load_en;
   logic             clear;
   logic             wr_en;
   logic [PCW-1:0]   wr_addr;
   logic [31:0]      wr_data;
   logic [PCW:0]     words_loaded;
   logic             full;
   logic             frame_err;
   logic             busy;

   wr_t         gotQ[$];
   wr_t         expQ[$];
   longint      cycleCnt = 0;
   int          testsRun = 0;
   int          testsFailed = 0;

   int          mIdx;
   int          mCount;
   logic [31:0] mWord;
   bit          mFull;
   bit          mErr;
   int          idleBits;

   uart_instr_loader #(.INSTR_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .load_en      (load_en),
      .clear        (clear),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .words_loaded (words_loaded),
      .full         (full),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   // 100 MHz-style bench clock
   always #5 clk = ~clk;

   // Free-running cycle counter for latency measurement
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Capture every write strobe seen on the memory port
   always @(negedge clk) begin
      wr_t w;
      if (rst_n && wr_en) begin
         w.addr = int'(wr_addr);
         w.data = wr_data;
         w.cyc  = cycleCnt;
         gotQ.push_back(w);
      end
   end

   // Hard stop in case the DUT or bench stalls
   initial begin
      #(95_000 * 10);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic waitBits(input int n);
      waitCycles(n * CPB);
      idleBits += n;
   endtask

   task automatic modelClear();
      mIdx   = 0;
      mCount = 0;
      mFull  = 1'b0;
      mErr   = 1'b0;
   endtask

   task automatic modelTimeout();
      if (idleBits >= GAP_IDLE_BITS) mIdx = 0;
   endtask

   task automatic modelByte(input logic [7:0] b, input logic stopBit, input logic en, input longint start);
      wr_t e;
      modelTimeout();
      if (!stopBit) begin
         mErr = 1'b1;
         mIdx = 0;
      end else if (en && !mFull) begin
         mWord = {mWord[23:0], b};
         mIdx++;
         if (mIdx == 4) begin
            e.addr = (mCount < DEPTH) ? mCount : DEPTH - 1;
            e.data = mWord;
            e.cyc  = start;
            expQ.push_back(e);
            mIdx   = 0;
            mCount++;
            mFull  = (mCount == DEPTH);
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int idleAfter);
      longint start;
      rx    = 1'b0;
      start = cycleCnt;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         waitCycles(CPB);
      end
      rx = stopBit;
      waitCycles(CPB);
      rx = 1'b1;
      modelByte(b, stopBit, load_en, start);
      idleBits = 0;
      if (idleAfter > 0) waitBits(idleAfter);
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      waitCycles(1);
      clear = 1'b0;
      modelClear();
      waitCycles(2);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_words"}, 64'(words_loaded), 64'(mCount));
      checkOutput({tag, "_full"}, 64'(full), 64'(mFull));
      checkOutput({tag, "_ferr"}, 64'(frame_err), 64'(mErr));
   endtask

   task automatic compareWrites(input string tag);
      wr_t g;
      wr_t e;
      checkOutput({tag, "_nwr"}, 64'(gotQ.size()), 64'(expQ.size()));
      while (gotQ.size() > 0 && expQ.size() > 0) begin
         g = gotQ.pop_front();
         e = expQ.pop_front();
         checkOutput({tag, "_addr"}, 64'(g.addr), 64'(e.addr));
         checkOutput({tag, "_data"}, 64'(g.data), 64'(e.data));
         checkOutput({tag, "_lat"}, 64'(g.cyc - e.cyc), 64'(WRITE_LATENCY));
      end
      gotQ.delete();
      expQ.delete();
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] fixedWord;
      rst_n    = 1'b0;
      rx       = 1'b1;
      load_en  = 1'b0;
      clear    = 1'b0;
      mWord    = '0;
      idleBits = 0;
      modelClear();
      waitCycles(5);
      rst_n = 1'b1;
      waitCycles(3);

      // reset values
      checkOutput("rst_wr_en", 64'(wr_en), 64'(0));
      checkOutput("rst_wr_addr", 64'(wr_addr), 64'(0));
      checkOutput("rst_wr_data", 64'(wr_data), 64'(0));
      checkOutput("rst_words", 64'(words_loaded), 64'(0));
      checkOutput("rst_full", 64'(full), 64'(0));
      checkOutput("rst_ferr", 64'(frame_err), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));

      // single word DEADBEEF
      load_en   = 1'b1;
      fixedWord = 32'hDEADBEEF;
      for (int i = 3; i >= 0; i--) applyStimulus(fixedWord[i*8 +: 8], 1'b1, 1);
      compareWrites("deadbeef");
      checkOutput("deadbeef_words", 64'(words_loaded), 64'(1));
      checkOutput("deadbeef_value", 64'(wr_data), 64'(32'hDEADBEEF));

      // three words back-to-back, no idle bits
      pulseClear();
      for (int i = 0; i < 12; i++) applyStimulus(8'($urandom), 1'b1, 0);
      waitCycles(5);
      checkOutput("b2b_busy", 64'(busy), 64'(0));
      compareWrites("b2b");
      checkState("b2b");

      // glitch: short low pulse is a false start
      rx = 1'b0;
      waitCycles(10);
      checkOutput("glitch_busy_hi", 64'(busy), 64'(1));
      rx = 1'b1;
      waitCycles(60);
      idleBits += 2;
      checkOutput("glitch_busy_lo", 64'(busy), 64'(0));
      compareWrites("glitch");
      checkState("glitch");

      // bad stop bit followed by a good word
      pulseClear();
      applyStimulus(8'h12, 1'b0, 1);
      fixedWord = 32'h11223344;
      for (int i = 3; i >= 0; i--) applyStimulus(fixedWord[i*8 +: 8], 1'b1, 1);
      compareWrites("ferr");
      checkState("ferr");
      checkOutput("ferr_flag", 64'(frame_err), 64'(1));

      // partial word abandoned by a long idle gap
      applyStimulus(8'($urandom), 1'b1, 0);
      applyStimulus(8'($urandom), 1'b1, 25);
      fixedWord = 32'hA0A1A2A3;
      for (int i = 3; i >= 0; i--) applyStimulus(fixedWord[i*8 +: 8], 1'b1, 1);
      compareWrites("timeout");
      checkState("timeout");

      // reset in the middle of a frame with a partial word held
      applyStimulus(8'($urandom), 1'b1, 0);
      applyStimulus(8'($urandom), 1'b1, 0);
      rx = 1'b0;
      waitCycles(4 * CPB);
      rst_n = 1'b0;
      rx    = 1'b1;
      waitCycles(3);
      rst_n = 1'b1;
      modelClear();
      idleBits = 0;
      waitCycles(5);
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      checkState("midrst");
      for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b1, 1);
      compareWrites("midrst");

      // fill memory, fifth word ignored, clear re-enables at address 0
      pulseClear();
      for (int i = 0; i < 20; i++) applyStimulus(8'($urandom), 1'b1, $urandom_range(0, 1));
      waitCycles(5);
      compareWrites("fill");
      checkState("fill");
      checkOutput("fill_full", 64'(full), 64'(1));
      checkOutput("fill_addr_hold", 64'(wr_addr), 64'(DEPTH - 1));
      pulseClear();
      checkState("clr");
      for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b1, 1);
      compareWrites("refill");
      checkState("refill");

      // randomized mix of enables, frame errors, gaps and clears
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 11) == 0) pulseClear();
         load_en = ($urandom_range(0, 5) != 0);
         b = 8'($urandom);
         applyStimulus(b, ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 9) == 0) ? 25 : $urandom_range(0, 3));
      end
      waitBits(2);
      modelTimeout();
      compareWrites("rand");
      checkState("rand");
      checkOutput("rand_busy", 64'(busy), 64'(mIdx != 0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
